// File: rtl/gan_param_ram.sv
// gan_param_ram: weight/bias parameter RAM with init sweep and saturating delta-update pipeline.
// Define GAN_PARAM_LFSR_INIT_EN to seed weights from a 16-bit LFSR during the sweep.
module gan_param_ram #(
  parameter int          WW        = 8,
  parameter int          BW        = 16,
  parameter int          W_DEPTH   = 64,
  parameter int          B_DEPTH   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int AW = $clog2(W_DEPTH),
  localparam int AB = $clog2(B_DEPTH),
  localparam int UA = (AW > AB) ? AW : AB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] w_rd_addr,
  output logic [WW-1:0] w_rd_data,
  input  logic [AB-1:0] b_rd_addr,
  output logic [BW-1:0] b_rd_data,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  logic          upd_sel,
  input  logic [UA-1:0] upd_addr,
  input  logic [BW-1:0] upd_delta,
  output logic          upd_done,
  output logic          init_done
);
  localparam int D  = (W_DEPTH > B_DEPTH) ? W_DEPTH : B_DEPTH;
  localparam int CW = $clog2(D + 1);
  localparam logic [AW:0] W_LIM = (AW + 1)'(W_DEPTH);
  localparam logic [AB:0] B_LIM = (AB + 1)'(B_DEPTH);
  localparam logic signed [BW:0] W_MAX = (BW + 1)'((1 << (WW - 1)) - 1);
  localparam logic signed [BW:0] W_MIN = ~W_MAX;
  localparam logic signed [BW:0] B_MAX = (BW + 1)'((1 << (BW - 1)) - 1);
  localparam logic signed [BW:0] B_MIN = ~B_MAX;

  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  typedef enum logic {SWEEP, RUN} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          w_sweep;
  logic [WW-1:0] w_init_w;

  logic [WW-1:0] r_wmem [W_DEPTH];
  logic [BW-1:0] r_bmem [B_DEPTH];
  logic [WW-1:0] r_w_rd;
  logic [BW-1:0] r_b_rd;

  logic          r_s1_v, r_s1_sel, r_s2_v, r_s2_sel, r_done;
  logic [UA-1:0] r_s1_addr, r_s2_addr;
  logic [BW-1:0] r_s1_delta, r_s2_delta, r_s2_old;

  logic          w_s1_ok, w_s2_ok, w_fwd;
  logic [WW-1:0] w_s1_wv;
  logic [BW-1:0] w_s1_old, w_new;
  logic signed [BW:0] w_sum, w_hi, w_lo;

  logic          w_wm_we, w_bm_we;
  logic [AW-1:0] w_wm_addr;
  logic [AB-1:0] w_bm_addr;
  logic [WW-1:0] w_wm_data;
  logic [BW-1:0] w_bm_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SWEEP;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == SWEEP && r_cnt == CW'(D)) w_state_nxt = RUN;
  end

  assign w_sweep = (r_state == SWEEP) && (r_cnt != CW'(D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_sweep) r_cnt <= r_cnt + 1'b1;
  end

`ifdef GAN_PARAM_LFSR_INIT_EN
  logic [15:0] r_lfsr;
  // Fibonacci taps 16,14,13,11; low six bits give small signed initial weights
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_lfsr <= LFSR_SEED;
    else if (w_sweep) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_init_w = {{(WW - 6){r_lfsr[5]}}, r_lfsr[5:0]};
`else
  assign w_init_w = '0;
`endif

  assign w_s1_ok  = r_s1_sel ? ({1'b0, r_s1_addr[AB-1:0]} < B_LIM) : ({1'b0, r_s1_addr[AW-1:0]} < W_LIM);
  assign w_s2_ok  = r_s2_sel ? ({1'b0, r_s2_addr[AB-1:0]} < B_LIM) : ({1'b0, r_s2_addr[AW-1:0]} < W_LIM);
  assign w_s1_wv  = r_wmem[r_s1_addr[AW-1:0]];
  assign w_s1_old = !w_s1_ok ? '0 :
                    r_s1_sel ? r_bmem[r_s1_addr[AB-1:0]] : {{(BW - WW){w_s1_wv[WW-1]}}, w_s1_wv};
  // Same-target update one stage ahead has not reached the array yet
  assign w_fwd = r_s2_v && w_s2_ok && (r_s2_sel == r_s1_sel) &&
                 (r_s1_sel ? (r_s2_addr[AB-1:0] == r_s1_addr[AB-1:0])
                           : (r_s2_addr[AW-1:0] == r_s1_addr[AW-1:0]));

  assign w_sum = {r_s2_old[BW-1], r_s2_old} + {r_s2_delta[BW-1], r_s2_delta};
  assign w_hi  = r_s2_sel ? B_MAX : W_MAX;
  assign w_lo  = r_s2_sel ? B_MIN : W_MIN;
  assign w_new = (w_sum > w_hi) ? w_hi[BW-1:0] : (w_sum < w_lo) ? w_lo[BW-1:0] : w_sum[BW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_sel   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_delta <= '0;
      r_s2_v     <= 1'b0;
      r_s2_sel   <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_delta <= '0;
      r_s2_old   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_s1_v     <= upd_valid && upd_ready;
      r_s1_sel   <= upd_sel;
      r_s1_addr  <= upd_addr;
      r_s1_delta <= upd_delta;
      r_s2_v     <= r_s1_v;
      r_s2_sel   <= r_s1_sel;
      r_s2_addr  <= r_s1_addr;
      r_s2_delta <= r_s1_delta;
      r_s2_old   <= w_fwd ? w_new : w_s1_old;
      r_done     <= r_s2_v;
    end
  end

  assign w_wm_we   = w_sweep ? (r_cnt < CW'(W_DEPTH)) : (r_s2_v && !r_s2_sel && w_s2_ok);
  assign w_wm_addr = w_sweep ? r_cnt[AW-1:0] : r_s2_addr[AW-1:0];
  assign w_wm_data = w_sweep ? w_init_w : w_new[WW-1:0];
  assign w_bm_we   = w_sweep ? (r_cnt < CW'(B_DEPTH)) : (r_s2_v && r_s2_sel && w_s2_ok);
  assign w_bm_addr = w_sweep ? r_cnt[AB-1:0] : r_s2_addr[AB-1:0];
  assign w_bm_data = w_sweep ? '0 : w_new;

  always_ff @(posedge clk) begin
    if (w_wm_we) r_wmem[w_wm_addr] <= w_wm_data;
    if (w_bm_we) r_bmem[w_bm_addr] <= w_bm_data;
  end

  // Registered reads sample the array before same-edge writes land (read-first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_rd <= '0;
      r_b_rd <= '0;
    end else begin
      r_w_rd <= (r_state == RUN && {1'b0, w_rd_addr} < W_LIM) ? r_wmem[w_rd_addr] : '0;
      r_b_rd <= (r_state == RUN && {1'b0, b_rd_addr} < B_LIM) ? r_bmem[b_rd_addr] : '0;
    end
  end

  assign w_rd_data = r_w_rd;
  assign b_rd_data = r_b_rd;
  assign upd_ready = (r_state == RUN);
  assign init_done = (r_state == RUN);
  assign upd_done  = r_done;
endmodule

// File: doc/gan_param_ram.md
GAN_PARAM_RAM -- requirements
Module: gan_param_ram

Interface
REQ-001 Parameter WW, default 8: weight width, signed Q1.(WW-1).
REQ-002 Parameter BW, default 16: bias and delta width, signed Q8.8.
REQ-003 Parameter W_DEPTH, default 64: weight entries; AW = $clog2(W_DEPTH).
REQ-004 Parameter B_DEPTH, default 16: bias entries; AB = $clog2(B_DEPTH).
REQ-005 Parameter LFSR_SEED, default 16'hACE1: init LFSR seed, must be nonzero.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 w_rd_addr  in  AW  weight read address.
REQ-009 w_rd_data  out  WW  weight read data.
REQ-010 b_rd_addr  in  AB  bias read address.
REQ-011 b_rd_data  out  BW  bias read data.
REQ-012 upd_valid  in  1  update request.
REQ-013 upd_ready  out  1  update accepted when valid&ready.
REQ-014 upd_sel  in  1  0 = weight array, 1 = bias array.
REQ-015 upd_addr  in  max(AW,AB)  target entry; for weights only low AW bits used, for biases only low AB bits.
REQ-016 upd_delta  in  BW  signed increment, same LSB weighting as target word.
REQ-017 upd_done  out  1  one-cycle pulse when an update is written.
REQ-018 init_done  out  1  high once the init sweep has finished.

Function
REQ-019 Both arrays SHALL be read synchronously: data for an address sampled at edge N appears after edge N, latency 1, one read per port per cycle.
REQ-020 Init sweep SHALL start on the first edge after rst_n deasserts, write entry i of both arrays in cycle i for i = 0..max(W_DEPTH,B_DEPTH)-1, and set init_done on the following edge.
REQ-021 During the sweep, upd_ready, w_rd_data and b_rd_data SHALL be 0.
REQ-022 After init, upd_ready SHALL be 1 every cycle; update throughput is one per cycle.
REQ-023 Update pipeline: S0 accept; S1 read old value; S2 compute and write; upd_done pulses on the S2 write edge, two cycles after acceptance.
REQ-024 Weight update: new = clamp(old sign-extended + delta, -2^(WW-1), 2^(WW-1)-1), computed in BW+1 bits.
REQ-025 Bias update: new = clamp(old + delta, -2^(BW-1), 2^(BW-1)-1), computed in BW+1 bits.
REQ-026 Back-to-back updates to the same array and address SHALL forward the S2 result into S1, so that N consecutive deltas accumulate exactly.
REQ-027 A read to an address being written on the same edge SHALL return the old value (read-first).
REQ-028 Addresses >= depth SHALL be ignored for writes and SHALL read as 0.

Reset
REQ-029 While rst_n = 0: all outputs 0, pipeline valids cleared, LFSR = LFSR_SEED, sweep counter 0.
REQ-030 Reset asserted mid-update or mid-sweep SHALL drop in-flight updates with no upd_done pulse, and the sweep restarts from entry 0 after release.

Configuration
REQ-031 Macro GAN_PARAM_LFSR_INIT_EN. When defined, sweep weight i = sign-extend of LFSR[5:0], range [-32,31] (|w| <= 0.25). A 16-bit Fibonacci LFSR with taps 16,14,13,11 advances once per sweep cycle. Biases are 0.
REQ-032 When GAN_PARAM_LFSR_INIT_EN is not defined, the sweep writes 0 to all weights and biases and no LFSR logic is present.

Verification
REQ-033 Release reset (defaults) -> init_done rises exactly 64 cycles after the first post-release edge; upd_ready stays 0 until then.
REQ-034 Macro off: after init, read all 64 weights and 16 biases -> every value is 0, latency 1.
REQ-035 Weight addr 3 = 0, updates with deltas +100 then +100 on consecutive cycles -> upd_done pulses twice, final read = 127 (saturated).
REQ-036 Bias addr 5 = 0, four back-to-back updates of -16'sd10000 -> final read = -32768, no wrap.
REQ-037 Update weight addr 7 with +5 while reading addr 7 on the write edge -> the read returns the old value, and the next read returns old+5.
REQ-038 Assert rst_n low one cycle after accepting an update -> no upd_done, and after re-init the target entry equals its init value.
